// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, coordinate type and helpers for the VGA raster generator.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;
    localparam int MAX_SYNC_DELAY = 4;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int h_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int v_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    // Half-open window test [start, start+len) done in int so a window ending at 1024 is safe.
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enabled shift register that re-aligns a sync signal with downstream pixel registers.
module vga_sync_delay #(
    parameter int   DEPTH = 1,
    parameter logic IDLE  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst ^ i_ce;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sr;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_sr <= {DEPTH{IDLE}};
                end else if (i_ce) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: DrawX/DrawY, visible flag, line/frame pulses, frame counter and delayed syncs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   SYNC_DELAY  = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        ce,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int     H_TOTAL   = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int     V_TOTAL   = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam int     HS_START  = H_VISIBLE + H_FRONT;
    localparam int     VS_START  = V_VISIBLE + V_FRONT;
    localparam logic   SYNC_IDLE = ~SYNC_ACTIVE;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
        end
    endgenerate

    coord_t      r_x;
    coord_t      r_y;
    logic        r_blank;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;
    logic        r_hs_raw;
    logic        r_vs_raw;

    logic        w_x_wrap;
    logic        w_y_wrap;
    coord_t      w_x_next;
    coord_t      w_y_next;
    logic        w_blank_next;
    logic        w_hs_next;
    logic        w_vs_next;
    logic        w_line_next;
    logic        w_frame_next;
    logic        w_hs_dly;
    logic        w_vs_dly;

    // Everything registered below is decoded from the next position so it lines up with DrawX/DrawY.
    always_comb begin
        w_x_wrap = (r_x == H_LAST);
        w_y_wrap = (r_y == V_LAST);
        w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
        w_y_next = r_y;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? '0 : r_y + coord_t'(1);
        end
        w_blank_next = (int'(w_x_next) < H_VISIBLE) && (int'(w_y_next) < V_VISIBLE);
        w_hs_next    = in_window(int'(w_x_next), HS_START, H_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
        w_vs_next    = in_window(int'(w_y_next), VS_START, V_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
        w_line_next  = (w_x_next == '0);
        w_frame_next = w_line_next && (w_y_next == '0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_hs_raw      <= SYNC_IDLE;
            r_vs_raw      <= SYNC_IDLE;
        end else if (ce) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_blank       <= w_blank_next;
            r_line_start  <= w_line_next;
            r_frame_start <= w_frame_next;
            r_hs_raw      <= w_hs_next;
            r_vs_raw      <= w_vs_next;
            if (w_frame_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end else begin
            // Pulses drop on a stalled edge so they never last longer than one cycle.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    vga_sync_delay #(
        .DEPTH (SYNC_DELAY),
        .IDLE  (SYNC_IDLE)
    ) u_hs_delay (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_ce  (ce),
        .i_d   (r_hs_raw),
        .o_q   (w_hs_dly)
    );

    vga_sync_delay #(
        .DEPTH (SYNC_DELAY),
        .IDLE  (SYNC_IDLE)
    ) u_vs_delay (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_ce  (ce),
        .i_d   (r_vs_raw),
        .o_q   (w_vs_dly)
    );

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign hs          = w_hs_dly;
    assign vs          = w_vs_dly;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances driven by one random clock-enable/reset stream.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, d;
        bit act;
    } tim_t;

    typedef struct {
        int x, y, fc;
        bit blank, hs, vs, ls, fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    logic [9:0]  dx0, dy0, dx1, dy1, dx2, dy2;
    logic        bl0, hs0, vs0, ls0, fs0;
    logic        bl1, hs1, vs1, ls1, fs1;
    logic        bl2, hs2, vs2, ls2, fs2;
    logic [15:0] fc0, fc1, fc2;

    vga_timing_gen #(.SYNC_ACTIVE(1'b0), .SYNC_DELAY(1)) dut0 (
        .vga_clk(clk), .reset(rst), .ce(ce), .DrawX(dx0), .DrawY(dy0), .blank(bl0),
        .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0));

    vga_timing_gen #(.SYNC_ACTIVE(1'b1), .SYNC_DELAY(0)) dut1 (
        .vga_clk(clk), .reset(rst), .ce(ce), .DrawX(dx1), .DrawY(dy1), .blank(bl1),
        .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1));

    vga_timing_gen #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
                     .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                     .SYNC_ACTIVE(1'b0), .SYNC_DELAY(3)) dut2 (
        .vga_clk(clk), .reset(rst), .ce(ce), .DrawX(dx2), .DrawY(dy2), .blank(bl2),
        .hs(hs2), .vs(vs2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2));

    int   vectors    = 0;
    int   miscompares = 0;
    int   n = 0;              // enabled edges since the last reset
    exp_t q[3][$];

    function automatic tim_t get_tim(input int i);
        tim_t t;
        case (i)
            0:       t = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, d:1, act:1'b0};
            1:       t = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, d:0, act:1'b1};
            default: t = '{hv:16,  hf:2,  hs:4,  hb:3,  vv:10,  vf:2,  vs:2, vb:3,  d:3, act:1'b0};
        endcase
        return t;
    endfunction

    function automatic bit sync_lvl(input int pos, input int start, input int len, input bit act);
        return (pos >= start && pos < start + len) ? act : !act;
    endfunction

    // Expected outputs after n enabled edges: position n-1 in raster order, syncs lag by d enabled edges.
    function automatic exp_t model(input tim_t t, input int n_edges, input bit edge_en);
        exp_t e;
        int ht = t.hv + t.hf + t.hs + t.hb;
        int vt = t.vv + t.vf + t.vs + t.vb;
        int p, m;
        if (n_edges == 0) begin
            e.x = ht - 1; e.y = vt - 1; e.blank = 1'b0; e.fc = 0;
        end else begin
            p = n_edges - 1;
            e.x = p % ht;
            e.y = (p / ht) % vt;
            e.blank = (e.x < t.hv) && (e.y < t.vv);
            e.fc = ((n_edges + ht * vt - 1) / (ht * vt)) % 65536;
        end
        m = n_edges - t.d;
        if (m >= 1) begin
            p = m - 1;
            e.hs = sync_lvl(p % ht, t.hv + t.hf, t.hs, t.act);
            e.vs = sync_lvl((p / ht) % vt, t.vv + t.vf, t.vs, t.act);
        end else begin
            e.hs = !t.act;
            e.vs = !t.act;
        end
        e.ls = edge_en && (e.x == 0);
        e.fs = e.ls && (e.y == 0);
        return e;
    endfunction

    task automatic chk(input int idx, input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL dut%0d %s: got %0d expected %0d at t=%0t", idx, name, act, req, $time);
        end
    endtask

    task automatic chk_dut(input int idx, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                           input logic bl, input logic h, input logic v, input logic ls,
                           input logic fs, input logic [15:0] fc);
        chk(idx, "DrawX", int'(x), e.x);
        chk(idx, "DrawY", int'(y), e.y);
        chk(idx, "blank", int'(bl), int'(e.blank));
        chk(idx, "hs", int'(h), int'(e.hs));
        chk(idx, "vs", int'(v), int'(e.vs));
        chk(idx, "line_start", int'(ls), int'(e.ls));
        chk(idx, "frame_start", int'(fs), int'(e.fs));
        chk(idx, "frame_count", int'(fc), e.fc);
    endtask

    // One cycle: account for the edge just taken, push expectations, then drive the next inputs mid-cycle.
    task automatic step(input bit next_ce, input bit next_rst);
        bit en;
        @(posedge clk);
        en = !rst && ce;
        if (rst) n = 0;
        else if (ce) n++;
        if (next_rst) begin
            n  = 0;
            en = 1'b0;
        end
        for (int i = 0; i < 3; i++) q[i].push_back(model(get_tim(i), n, en));
        #2;
        ce  = next_ce;
        rst = next_rst;
    endtask

    initial begin : monitor
        exp_t e0, e1, e2;
        forever begin
            @(negedge clk);
            if (q[0].size() > 0) begin
                e0 = q[0].pop_front();
                e1 = q[1].pop_front();
                e2 = q[2].pop_front();
                chk_dut(0, e0, dx0, dy0, bl0, hs0, vs0, ls0, fs0, fc0);
                chk_dut(1, e1, dx1, dy1, bl1, hs1, vs1, ls1, fs1, fc1);
                chk_dut(2, e2, dx2, dy2, bl2, hs2, vs2, ls2, fs2, fc2);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        ce = 1'b1;
        #1 rst = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (2000) step(1'b1, 1'b0);
        while (n < 4100) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (3000) step($urandom_range(0, 3) != 0, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (2500) step($urandom_range(0, 4) != 0, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
